point_cloud_loader: RTL and testbench

- Upstream stage of the DROR filter BRAM interface.
- Accepts a streamed LiDAR frame of (x,y,z) points and packs BUS_SIZE/N points per word.
- Writes the words into the three coordinate BRAMs (word 1 onward), then publishes the frame header at word 0.
- Header protocol: point count in x[0], go flag in y[0]. The filter stage consumes this header and signals completion with DONE_MAGIC in z[0].

---
 rtl/dror_pkg.sv | 24 ++
 rtl/lane_packer.sv | 46 ++++
 rtl/point_cloud_loader.sv | 165 ++++++++++++++++
 tb/tb_point_cloud_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dror_pkg.sv
// Shared constants and the loader state type for the DROR BRAM interface.
// The header word lives at HDR_ADDR; point data starts at DATA_BASE.
package dror_pkg;
    localparam int          N          = 16;
    localparam int          BUS_SIZE   = 32;
    localparam int          PPW        = BUS_SIZE / N;
    localparam int          MAX_POINTS = 4096;
    localparam int          HDR_ADDR   = 0;
    localparam int          DATA_BASE  = 1;
    localparam int          GO_FLAG    = 1;
    localparam logic [31:0] DONE_MAGIC = 32'h0000_0fff;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_WAIT,
        S_CHECK,
        S_CLR_Z,
        S_STREAM,
        S_FLUSH,
        S_HDR_X,
        S_HDR_Y,
        S_DONE
    } loader_state_e;
endpackage

// File: rtl/lane_packer.sv
// Per-axis packer: gathers LANES coordinates into one BRAM word, lane 0 in the low bits.
// word_o already contains the point being pushed, so a full word is written in the same cycle.
module lane_packer
    import dror_pkg::*;
#(
    parameter int W     = N,
    parameter int LANES = PPW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic [W-1:0]       din_i,
    output logic [LANES*W-1:0] word_o,
    output logic               full_o,
    output logic               pending_o
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES*W-1:0] word_q;
    logic [LW-1:0]      lane_q;

    always_comb begin
        word_o = word_q;
        if (push_i) word_o[int'(lane_q)*W +: W] = din_i;
    end

    assign full_o    = push_i && (lane_q == LW'(LANES - 1));
    assign pending_o = (lane_q != '0);

    // Clearing after every full word is what zero-pads the lanes of a partial flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            word_q <= '0;
            lane_q <= '0;
        end else if (push_i) begin
            if (full_o) begin
                word_q <= '0;
                lane_q <= '0;
            end else begin
                word_q <= word_o;
                lane_q <= lane_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/point_cloud_loader.sv
// Streams a LiDAR frame into the x/y/z coordinate BRAMs, then publishes count and go flag
// in word 0 once the filter stage has released the previous frame.
module point_cloud_loader #(
    parameter int          N          = dror_pkg::N,
    parameter int          BUS_SIZE   = dror_pkg::BUS_SIZE,
    parameter int          MAX_POINTS = dror_pkg::MAX_POINTS,
    parameter logic [31:0] DONE_MAGIC = dror_pkg::DONE_MAGIC
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N-1:0]            s_x,
    input  logic [N-1:0]            s_y,
    input  logic [N-1:0]            s_z,
    input  logic                    s_last,
    output logic [31:0]             addr_x,
    output logic [31:0]             addr_y,
    output logic [31:0]             addr_z,
    output logic [BUS_SIZE-1:0]     write_in_x,
    output logic [BUS_SIZE-1:0]     write_in_y,
    output logic [BUS_SIZE-1:0]     write_in_z,
    input  logic [BUS_SIZE-1:0]     read_out_y,
    input  logic [BUS_SIZE-1:0]     read_out_z,
    output logic                    en_x,
    output logic                    en_y,
    output logic                    en_z,
    output logic [15:0]             we_x,
    output logic [15:0]             we_y,
    output logic [15:0]             we_z,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overflow,
    output logic [15:0]             frames_loaded,
    output dror_pkg::loader_state_e state_dbg
);
    import dror_pkg::*;

    localparam int          PPW_L   = BUS_SIZE / N;
    localparam int          CW      = $clog2(MAX_POINTS + 1);
    localparam logic [15:0] WE_FULL = 16'((1 << (BUS_SIZE / 8)) - 1);

    loader_state_e    state_q, state_d;
    logic [CW-1:0]    point_cnt_q;
    logic [31:0]      word_addr_q;
    logic             first_frame_q;
    logic             overflow_q;
    logic [15:0]      frames_q;

    logic             accept, push, hdr_free, wr_word;
    logic [2:0]       full_v, pend_v;
    logic [PPW_L*N-1:0] word_x, word_y, word_z;

    assign accept   = (state_q == S_STREAM) && s_valid;
    assign push     = accept && (point_cnt_q < CW'(MAX_POINTS));
    // The first frame after reset has no prior filter run to wait for.
    assign hdr_free = (read_out_y == '0) &&
                      (first_frame_q || (read_out_z == BUS_SIZE'(DONE_MAGIC)));

    lane_packer #(.W(N), .LANES(PPW_L)) u_pack_x (
        .clk_i(clock), .rst_i(reset), .clr_i(state_q == S_DONE), .push_i(push),
        .din_i(s_x), .word_o(word_x), .full_o(full_v[0]), .pending_o(pend_v[0]));
    lane_packer #(.W(N), .LANES(PPW_L)) u_pack_y (
        .clk_i(clock), .rst_i(reset), .clr_i(state_q == S_DONE), .push_i(push),
        .din_i(s_y), .word_o(word_y), .full_o(full_v[1]), .pending_o(pend_v[1]));
    lane_packer #(.W(N), .LANES(PPW_L)) u_pack_z (
        .clk_i(clock), .rst_i(reset), .clr_i(state_q == S_DONE), .push_i(push),
        .din_i(s_z), .word_o(word_z), .full_o(full_v[2]), .pending_o(pend_v[2]));

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (s_valid) state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_CHECK;
            S_CHECK:   state_d = hdr_free ? S_CLR_Z : S_IDLE;
            S_CLR_Z:   state_d = S_STREAM;
            S_STREAM:  if (accept && s_last) state_d = S_FLUSH;
            S_FLUSH:   state_d = S_HDR_X;
            S_HDR_X:   state_d = S_HDR_Y;
            S_HDR_Y:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        busy       = (state_q != S_IDLE);
        frame_done = 1'b0;
        wr_word    = 1'b0;
        {en_x, en_y, en_z}                   = '0;
        {we_x, we_y, we_z}                   = '0;
        {addr_x, addr_y, addr_z}             = '0;
        {write_in_x, write_in_y, write_in_z} = '0;
        unique case (state_q)
            S_IDLE: if (s_valid) begin
                en_y   = 1'b1;
                en_z   = 1'b1;
                addr_y = 32'(HDR_ADDR);
                addr_z = 32'(HDR_ADDR);
            end
            S_CLR_Z: begin
                en_z   = 1'b1;
                we_z   = WE_FULL;
                addr_z = 32'(HDR_ADDR);
            end
            S_STREAM: begin
                s_ready = 1'b1;
                wr_word = |full_v;
            end
            S_FLUSH: wr_word = |pend_v;
            S_HDR_X: begin
                en_x       = 1'b1;
                we_x       = WE_FULL;
                addr_x     = 32'(HDR_ADDR);
                write_in_x = BUS_SIZE'(point_cnt_q);
            end
            S_HDR_Y: begin
                en_y       = 1'b1;
                we_y       = WE_FULL;
                addr_y     = 32'(HDR_ADDR);
                write_in_y = BUS_SIZE'(GO_FLAG);
            end
            S_DONE:  frame_done = 1'b1;
            default: ;
        endcase
        if (wr_word) begin
            {en_x, en_y, en_z}       = 3'b111;
            {we_x, we_y, we_z}       = {WE_FULL, WE_FULL, WE_FULL};
            {addr_x, addr_y, addr_z} = {word_addr_q, word_addr_q, word_addr_q};
            write_in_x = BUS_SIZE'(word_x);
            write_in_y = BUS_SIZE'(word_y);
            write_in_z = BUS_SIZE'(word_z);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            point_cnt_q   <= '0;
            word_addr_q   <= 32'(DATA_BASE);
            first_frame_q <= 1'b1;
            overflow_q    <= 1'b0;
            frames_q      <= '0;
        end else begin
            if (state_q == S_CLR_Z) first_frame_q <= 1'b0;
            if (push) point_cnt_q <= point_cnt_q + 1'b1;
            if (push && (|full_v)) word_addr_q <= word_addr_q + 32'd1;
            if (accept && !push) overflow_q <= 1'b1;
            if (state_q == S_DONE) begin
                frames_q    <= frames_q + 16'd1;
                point_cnt_q <= '0;
                word_addr_q <= 32'(DATA_BASE);
            end
        end
    end

    assign overflow      = overflow_q;
    assign frames_loaded = frames_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_point_cloud_loader.sv
// Directed bench for point_cloud_loader: two instances (full capacity and MAX_POINTS=4)
// share one BRAM model; every BRAM write is checked in order against an expected queue.
module tb_point_cloud_loader;
    import dror_pkg::*;

    localparam int EW = 66;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [15:0] s_x = '0, s_y = '0, s_z = '0;
    logic [31:0] rd_y = '0, rd_z = '0;
    logic        v_a, v_b;

    logic        o_rdy[2], o_busy[2], o_fd[2], o_ovf[2];
    logic [15:0] o_frames[2];
    loader_state_e o_state[2];
    logic        o_en[2][3];
    logic [15:0] o_we[2][3];
    logic [31:0] o_addr[2][3];
    logic [31:0] o_wd[2][3];

    logic        m_rdy, m_busy, m_fd, m_ovf;
    logic [15:0] m_frames;
    loader_state_e m_state;
    logic        m_en[3];
    logic [15:0] m_we[3];
    logic [31:0] m_addr[3];
    logic [31:0] m_wd[3];

    logic [31:0] mem_x[16], mem_y[16], mem_z[16];
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign v_a = s_valid & ~sel;
    assign v_b = s_valid & sel;

    point_cloud_loader #(.MAX_POINTS(4096)) dut_a (
        .clock(clock), .reset(reset), .s_valid(v_a), .s_ready(o_rdy[0]),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
        .addr_x(o_addr[0][0]), .addr_y(o_addr[0][1]), .addr_z(o_addr[0][2]),
        .write_in_x(o_wd[0][0]), .write_in_y(o_wd[0][1]), .write_in_z(o_wd[0][2]),
        .read_out_y(rd_y), .read_out_z(rd_z),
        .en_x(o_en[0][0]), .en_y(o_en[0][1]), .en_z(o_en[0][2]),
        .we_x(o_we[0][0]), .we_y(o_we[0][1]), .we_z(o_we[0][2]),
        .busy(o_busy[0]), .frame_done(o_fd[0]), .overflow(o_ovf[0]),
        .frames_loaded(o_frames[0]), .state_dbg(o_state[0]));

    point_cloud_loader #(.MAX_POINTS(4)) dut_b (
        .clock(clock), .reset(reset), .s_valid(v_b), .s_ready(o_rdy[1]),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
        .addr_x(o_addr[1][0]), .addr_y(o_addr[1][1]), .addr_z(o_addr[1][2]),
        .write_in_x(o_wd[1][0]), .write_in_y(o_wd[1][1]), .write_in_z(o_wd[1][2]),
        .read_out_y(rd_y), .read_out_z(rd_z),
        .en_x(o_en[1][0]), .en_y(o_en[1][1]), .en_z(o_en[1][2]),
        .we_x(o_we[1][0]), .we_y(o_we[1][1]), .we_z(o_we[1][2]),
        .busy(o_busy[1]), .frame_done(o_fd[1]), .overflow(o_ovf[1]),
        .frames_loaded(o_frames[1]), .state_dbg(o_state[1]));

    always_comb begin
        m_rdy    = o_rdy[sel];
        m_busy   = o_busy[sel];
        m_fd     = o_fd[sel];
        m_ovf    = o_ovf[sel];
        m_frames = o_frames[sel];
        m_state  = o_state[sel];
        for (int a = 0; a < 3; a++) begin
            m_en[a]   = o_en[sel][a];
            m_we[a]   = o_we[sel][a];
            m_addr[a] = o_addr[sel][a];
            m_wd[a]   = o_wd[sel][a];
        end
    end

    // BRAM read port: one-cycle latency, output held when not reading.
    always @(posedge clock) begin
        if (m_en[1] && m_we[1] == 16'h0) rd_y <= mem_y[m_addr[1][3:0]];
        if (m_en[2] && m_we[2] == 16'h0) rd_z <= mem_z[m_addr[2][3:0]];
    end

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every write the DUT presents is popped against the expected queue.
    always @(negedge clock) begin
        logic [EW-1:0] got, e;
        for (int a = 0; a < 3; a++) begin
            if (m_en[a] && m_we[a] != 16'h0) begin
                got = {a[1:0], m_addr[a], m_wd[a]};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected: got 0x%0h, expected no write", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL write_data: got 0x%0h, expected 0x%0h", got, e);
                    end
                end
                check("write_we", m_we[a], 16'h000f);
                case (a)
                    0: mem_x[m_addr[a][3:0]] = m_wd[a];
                    1: mem_y[m_addr[a][3:0]] = m_wd[a];
                    default: mem_z[m_addr[a][3:0]] = m_wd[a];
                endcase
            end
        end
    end

    function automatic logic [15:0] coord(input int axis, input int base, input int i);
        return 16'((axis + 1) * 4096 + base * 256 + i);
    endfunction

    function automatic logic [31:0] word_data(input int axis, input int base, input int k, input int w);
        logic [15:0] lo, hi;
        lo = coord(axis, base, 2 * w);
        hi = (2 * w + 1 < k) ? coord(axis, base, 2 * w + 1) : 16'h0;
        return {hi, lo};
    endfunction

    task automatic exp_push(input int axis, input int addr, input logic [31:0] data);
        exp_q.push_back({axis[1:0], addr[31:0], data});
    endtask

    task automatic exp_frame(input int base, input int n, input int maxp, input bit header);
        int k;
        k = (n < maxp) ? n : maxp;
        exp_push(2, 0, 32'h0);
        for (int w = 0; w < (k + 1) / 2; w++)
            for (int ax = 0; ax < 3; ax++) exp_push(ax, 1 + w, word_data(ax, base, k, w));
        if (header) begin
            exp_push(0, 0, k);
            exp_push(1, 0, 32'h1);
        end
    endtask

    task automatic present(input int base, input int i, input bit last);
        s_valid = 1'b1;
        s_last  = last;
        s_x = coord(0, base, i);
        s_y = coord(1, base, i);
        s_z = coord(2, base, i);
    endtask

    task automatic send_beat(input int base, input int i, input bit last, output bit ok);
        present(base, i, last);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (m_rdy) begin
                ok = 1'b1;
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_timeout: beat %0d of frame %0d got no s_ready, expected acceptance", i, base);
        end
    endtask

    task automatic send_frame(input int base, input int n, output int acc);
        bit ok;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(base, i, i == n - 1, ok);
            if (ok) acc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_frame(input int exp_frames, input bit exp_ovf);
        int lat;
        bit fd;
        lat = 0;
        fd  = 1'b0;
        while (!fd && lat < 20) begin
            @(negedge clock);
            lat++;
            fd = m_fd;
        end
        check("done_latency", lat, 4);
        @(negedge clock);
        check("done_pulse", m_fd, 1'b0);
        check("frames_loaded", m_frames, exp_frames);
        check("overflow", m_ovf, exp_ovf);
        check("busy_after_done", m_busy, 1'b0);
        check("writes_pending", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        for (int a = 0; a < 3; a++) begin
            check("rst_en", m_en[a], 1'b0);
            check("rst_we", m_we[a], 16'h0);
            check("rst_addr", m_addr[a], 32'h0);
            check("rst_wdata", m_wd[a], 32'h0);
        end
        check("rst_s_ready", m_rdy, 1'b0);
        check("rst_busy", m_busy, 1'b0);
        check("rst_frame_done", m_fd, 1'b0);
        check("rst_overflow", m_ovf, 1'b0);
        check("rst_frames", m_frames, 16'h0);
        check("rst_state", m_state, S_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        bit ok, busy_seen;
        for (int i = 0; i < 16; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
            mem_z[i] = '0;
        end

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs();
        @(posedge clock); #1;
        reset = 1'b0;

        // Frame 1: 5 points, first frame bypasses the done check.
        exp_frame(1, 5, 4096, 1);
        send_frame(1, 5, acc);
        check("f1_accepted", acc, 5);
        finish_frame(1, 0);
        check("f1_hdr_x", mem_x[0], 32'd5);
        check("f1_hdr_y", mem_y[0], 32'd1);
        check("f1_word3_pad", mem_x[3], 32'h0000_1104);

        // Frame 2: go flag still set, loader must hold off.
        present(2, 0, 1'b0);
        repeat (20) begin
            @(negedge clock);
            check("stall_go_ready", m_rdy, 1'b0);
        end
        @(posedge clock); #1;
        exp_frame(2, 4, 4096, 1);
        mem_y[0] = 32'h0;
        mem_z[0] = 32'h0000_0fff;
        send_frame(2, 4, acc);
        check("f2_accepted", acc, 4);
        finish_frame(2, 0);
        check("f2_hdr_x", mem_x[0], 32'd4);
        check("f2_word2", mem_y[2], 32'h2203_2202);

        // Frame 3: flag consumed but no DONE_MAGIC yet, loader keeps polling.
        mem_y[0] = 32'h0;
        present(3, 0, 1'b0);
        busy_seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            check("stall_magic_ready", m_rdy, 1'b0);
            busy_seen |= m_busy;
        end
        check("stall_magic_busy", busy_seen, 1'b1);
        @(posedge clock); #1;
        exp_frame(3, 2, 4096, 0);
        mem_z[0] = 32'h0000_0fff;
        send_beat(3, 0, 1'b0, ok);
        send_beat(3, 1, 1'b0, ok);
        present(3, 2, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        s_valid = 1'b0;
        reset   = 1'b0;
        @(negedge clock);
        check_reset_outputs();
        repeat (10) @(negedge clock);
        check("abandon_pending", exp_q.size(), 0);
        check("abandon_no_hdr", mem_y[0], 32'h0);

        // Frame 4: after reset the first-frame bypass applies again, data restarts at word 1.
        exp_frame(4, 3, 4096, 1);
        send_frame(4, 3, acc);
        check("f4_accepted", acc, 3);
        finish_frame(1, 0);
        check("f4_word2", mem_z[2], 32'h0000_3402);

        // Frame 5 on the MAX_POINTS=4 instance: 7 beats, only 4 kept.
        @(posedge clock); #1;
        sel = 1'b1;
        mem_y[0] = 32'h0;
        exp_frame(5, 7, 4, 1);
        send_frame(5, 7, acc);
        check("f5_accepted", acc, 7);
        finish_frame(1, 1);
        check("f5_hdr_x", mem_x[0], 32'd4);

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
